// File: rtl/itof_pipe_if.sv
// Operand/result handshake bundle for the integer-to-float pipeline.
// slave = converter side, master = issue/writeback side.
interface itof_pipe_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_data, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_data, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/itof_pipe.sv
// Three-stage signed int32 -> IEEE-754 single converter with valid/ready on both sides.
// Define ITOF_RNE_EN for round-to-nearest-even; default rounds half away from zero.
module itof_pipe #(
    parameter int TAG_W = 5
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush,
    output logic        busy,
    itof_pipe_if.slave  bus
);

    typedef struct packed {
        logic             s;
        logic             z;
        logic [31:0]      u;
        logic [TAG_W-1:0] tag;
    } s1_t;

    // frac holds n[30:7]: 23 mantissa bits followed by the guard bit
    typedef struct packed {
        logic             s;
        logic             z;
        logic [4:0]       p;
        logic [23:0]      frac;
`ifdef ITOF_RNE_EN
        logic             st;
`endif
        logic [TAG_W-1:0] tag;
    } s2_t;

    typedef struct packed {
        logic [31:0]      f;
        logic [TAG_W-1:0] tag;
    } s3_t;

    logic [3:1] vld_pipe;
    logic       ld1, ld2, ld3;
    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    s3_t        s3_d, s3_q;
    logic [4:0] p1, sh1;
    logic       rnd;
    logic [23:0] msum;
    logic [7:0] expo;

    function automatic logic [4:0] msb_idx(input logic [31:0] v);
        msb_idx = '0;
        for (int i = 0; i < 32; i++)
            if (v[i]) msb_idx = 5'(i);
    endfunction

    // stage k may load when empty or when its successor takes its contents
    assign ld3 = !vld_pipe[3] || bus.out_ready;
    assign ld2 = !vld_pipe[2] || ld3;
    assign ld1 = !vld_pipe[1] || ld2;

    assign bus.in_ready  = !flush && ld1;
    assign bus.out_valid = vld_pipe[3];
    assign bus.out_data  = s3_q.f;
    assign bus.out_tag   = s3_q.tag;
    assign busy          = |vld_pipe;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
        end else if (flush) begin
            vld_pipe <= '0;
        end else begin
            if (ld1) vld_pipe[1] <= bus.in_valid;
            if (ld2) vld_pipe[2] <= vld_pipe[1];
            if (ld3) vld_pipe[3] <= vld_pipe[2];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            if (ld1 && bus.in_valid) s1_q <= s1_d;
            if (ld2 && vld_pipe[1])  s2_q <= s2_d;
            if (ld3 && vld_pipe[2])  s3_q <= s3_d;
        end
    end

    // S1: sign/magnitude split; 0x80000000 negates to itself, which is right unsigned
    always_comb begin
        s1_d.s   = bus.in_data[31];
        s1_d.u   = bus.in_data[31] ? (~bus.in_data + 32'd1) : bus.in_data;
        s1_d.z   = (bus.in_data == 32'd0);
        s1_d.tag = bus.in_tag;
    end

    // S2: normalise so the leading one sits at bit 31
    always_comb begin
        p1        = msb_idx(s1_q.u);
        sh1       = 5'd31 - p1;
        s2_d.s    = s1_q.s;
        s2_d.z    = s1_q.z;
        s2_d.p    = p1;
        s2_d.frac = 24'((s1_q.u << sh1) >> 7);
`ifdef ITOF_RNE_EN
        s2_d.st   = |(7'(s1_q.u << sh1));
`endif
        s2_d.tag  = s1_q.tag;
    end

    // S3: round, fold mantissa carry into the exponent, pack
    always_comb begin
`ifdef ITOF_RNE_EN
        rnd = s2_q.frac[0] && (s2_q.st || s2_q.frac[1]);
`else
        rnd = s2_q.frac[0];
`endif
        msum     = {1'b0, s2_q.frac[23:1]} + {23'd0, rnd};
        expo     = 8'd127 + {3'd0, s2_q.p} + {7'd0, msum[23]};
        s3_d.f   = s2_q.z ? 32'd0 : {s2_q.s, expo, msum[22:0]};
        s3_d.tag = s2_q.tag;
    end

endmodule
